// File: rtl/spio_spinnaker_link_tb_driver.sv
// ---------------------------------------------------------------------------
// spio_spinnaker_link_tb_driver
//
// Verification-side SpiNNaker link transmitter. Takes 72-bit packets on a
// valid/ready interface and sends them as NRZ 2-of-7 symbols, one symbol per
// ack transition returned by the receiver under test. Flags spurious acks
// and ack timeouts, and counts completed packets.
//
// Ports:
//   tb_clk, tb_rst       clock, asynchronous active-high reset
//   PKT_DATA_IN[71:0]    [7:0] header, [39:8] key, [71:40] payload
//   PKT_VLD_IN           packet valid
//   PKT_RDY_OUT          packet ready (registered, high only in IDLE)
//   SL_DATA_2OF7_OUT[6:0] NRZ 2-of-7 link data
//   SL_ACK_IN            link ack, asynchronous to tb_clk
//   ACK_ERR_OUT          one-cycle pulse: ack arrived while credit was held
//   TMO_ERR_OUT          one-cycle pulse: no ack within ACK_TMO cycles
//   PKT_CNT_OUT[31:0]    packets whose EOP has been sent (wraps)
// ---------------------------------------------------------------------------
module spio_spinnaker_link_tb_driver #(
    parameter int ACK_TMO = 255,
    parameter int SYM_DLY = 0
) (
    input  logic        tb_clk,
    input  logic        tb_rst,
    input  logic [71:0] PKT_DATA_IN,
    input  logic        PKT_VLD_IN,
    output logic        PKT_RDY_OUT,
    output logic [6:0]  SL_DATA_2OF7_OUT,
    input  logic        SL_ACK_IN,
    output logic        ACK_ERR_OUT,
    output logic        TMO_ERR_OUT,
    output logic [31:0] PKT_CNT_OUT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_EOP  = 2'd2;

    localparam logic [7:0]  GAP_INIT   = 8'(SYM_DLY);
    localparam logic [15:0] TMO_LIM    = 16'(ACK_TMO);
    localparam logic [15:0] TMO_LIM_M1 = 16'(ACK_TMO - 1);
    localparam logic [6:0]  EOP_CODE   = 7'h60;

    function automatic logic [6:0] code_of(input logic [3:0] n);
        case (n)
            4'h0: code_of = 7'h11;
            4'h1: code_of = 7'h12;
            4'h2: code_of = 7'h14;
            4'h3: code_of = 7'h18;
            4'h4: code_of = 7'h21;
            4'h5: code_of = 7'h22;
            4'h6: code_of = 7'h24;
            4'h7: code_of = 7'h28;
            4'h8: code_of = 7'h41;
            4'h9: code_of = 7'h42;
            4'hA: code_of = 7'h44;
            4'hB: code_of = 7'h48;
            4'hC: code_of = 7'h03;
            4'hD: code_of = 7'h06;
            4'hE: code_of = 7'h0C;
            default: code_of = 7'h09;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [71:0] pkt_q, pkt_d;        // shifted right one nibble per symbol
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  gap_q, gap_d;
    logic        credit_q, credit_d;
    logic        sent_q, sent_d;      // any symbol sent since reset
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        s1_q, s2_q, edge_q;
    logic [6:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        ack_err_q, ack_err_d;
    logic        tmo_q, tmo_d;
    logic [31:0] pcnt_q, pcnt_d;

    logic ack_edge, send, outstanding;

    assign ack_edge    = s2_q ^ edge_q;
    assign send        = (state_q != ST_IDLE) && credit_q && (gap_q == 8'd0);
    assign outstanding = ~credit_q & sent_q;

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        data_d    = data_q;
        pcnt_d    = pcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (PKT_VLD_IN && rdy_q) begin
                    pkt_d   = PKT_DATA_IN;
                    cnt_d   = 5'd0;
                    len_d   = PKT_DATA_IN[1] ? 5'd18 : 5'd10;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send) begin
                    data_d = data_q ^ code_of(pkt_q[3:0]);
                    pkt_d  = pkt_q >> 4;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == len_q - 5'd1) state_d = ST_EOP;
                end
            end
            ST_EOP: begin
                if (send) begin
                    data_d  = data_q ^ EOP_CODE;
                    pcnt_d  = pcnt_q + 32'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gap_d     = send ? GAP_INIT : ((gap_q != 8'd0) ? gap_q - 8'd1 : gap_q);
        // An ack in the same cycle as a send refills the credit just spent.
        credit_d  = ack_edge | (credit_q & ~send);
        ack_err_d = ack_edge & credit_q;
        sent_d    = sent_q | send;

        // Counter saturates at the limit so the pulse fires only once.
        tmo_cnt_d = tmo_cnt_q;
        if (credit_q)
            tmo_cnt_d = 16'd0;
        else if (outstanding && tmo_cnt_q != TMO_LIM)
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        tmo_d = outstanding && (tmo_cnt_q == TMO_LIM_M1);

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q   <= ST_IDLE;
            pkt_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            credit_q  <= 1'b0;
            sent_q    <= 1'b0;
            tmo_cnt_q <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            edge_q    <= 1'b0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            ack_err_q <= 1'b0;
            tmo_q     <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            credit_q  <= credit_d;
            sent_q    <= sent_d;
            tmo_cnt_q <= tmo_cnt_d;
            s1_q      <= SL_ACK_IN;
            s2_q      <= s1_q;
            edge_q    <= s2_q;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            ack_err_q <= ack_err_d;
            tmo_q     <= tmo_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign PKT_RDY_OUT      = rdy_q;
    assign SL_DATA_2OF7_OUT = data_q;
    assign ACK_ERR_OUT      = ack_err_q;
    assign TMO_ERR_OUT      = tmo_q;
    assign PKT_CNT_OUT      = pcnt_q;

endmodule

// File: tb/tb_spio_spinnaker_link_tb_driver.sv
// ---------------------------------------------------------------------------
// Bench for spio_spinnaker_link_tb_driver. A negedge monitor decodes the NRZ
// symbol stream back into packets and acts as the ack responder; the main
// sequence drives packets and compares decoded results against a table.
// ---------------------------------------------------------------------------
module tb_spio_spinnaker_link_tb_driver;

    localparam int ACK_TMO = 40;
    localparam int SYM_DLY = 3;

    logic        tb_clk = 1'b0;
    logic        tb_rst;
    logic [71:0] PKT_DATA_IN;
    logic        PKT_VLD_IN;
    logic        PKT_RDY_OUT;
    logic [6:0]  SL_DATA_2OF7_OUT;
    logic        SL_ACK_IN;
    logic        ACK_ERR_OUT;
    logic        TMO_ERR_OUT;
    logic [31:0] PKT_CNT_OUT;

    spio_spinnaker_link_tb_driver #(.ACK_TMO(ACK_TMO), .SYM_DLY(SYM_DLY)) dut (
        .tb_clk(tb_clk), .tb_rst(tb_rst),
        .PKT_DATA_IN(PKT_DATA_IN), .PKT_VLD_IN(PKT_VLD_IN), .PKT_RDY_OUT(PKT_RDY_OUT),
        .SL_DATA_2OF7_OUT(SL_DATA_2OF7_OUT), .SL_ACK_IN(SL_ACK_IN),
        .ACK_ERR_OUT(ACK_ERR_OUT), .TMO_ERR_OUT(TMO_ERR_OUT), .PKT_CNT_OUT(PKT_CNT_OUT)
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [71:0] pkt;
        logic [71:0] exp;
        int          nsym;
    } vec_t;

    vec_t vt[4];
    int   errors = 0;
    int   checks = 0;

    // main-sequence controls (written only by the main block)
    int   tgl_req = 0;
    logic resp_en = 1'b0;
    int   resp_dly = 2;
    logic spc_en = 1'b0;

    // monitor state (written only by the monitor)
    int          cyc = 0;
    int          tgl_done = 0;
    int          timer = 0;
    logic [6:0]  prev = '0;
    logic [71:0] acc = '0;
    int          nib_n = 0;
    logic [71:0] rx_pkt[64];
    int          rx_nsym[64];
    int          rx_n = 0;
    logic [6:0]  traj[256];
    int          traj_n = 0;
    int          sym_total = 0;
    int          last_sym_cyc = 0;
    int          ack_err_n = 0;
    int          tmo_n = 0;
    int          tmo_cyc = 0;
    int          bad_n = 0;
    int          min_gap = 1000000;
    int          spc_last = -1;

    function automatic int nib_of(input logic [6:0] c);
        case (c)
            7'h11: return 0;  7'h12: return 1;  7'h14: return 2;  7'h18: return 3;
            7'h21: return 4;  7'h22: return 5;  7'h24: return 6;  7'h28: return 7;
            7'h41: return 8;  7'h42: return 9;  7'h44: return 10; 7'h48: return 11;
            7'h03: return 12; 7'h06: return 13; 7'h0C: return 14; 7'h09: return 15;
            7'h60: return 16;
            default: return 17;
        endcase
    endfunction

    initial begin
        SL_ACK_IN = 1'b0;
        forever begin
            @(negedge tb_clk);
            cyc++;
            if (!spc_en) begin min_gap = 1000000; spc_last = -1; end
            if (tb_rst) begin
                prev = '0; acc = '0; nib_n = 0; timer = 0;
                SL_ACK_IN = 1'b0; tgl_done = tgl_req;
            end else begin
                if (ACK_ERR_OUT) ack_err_n++;
                if (TMO_ERR_OUT) begin tmo_n++; tmo_cyc = cyc; end
                if (tgl_done != tgl_req) begin
                    SL_ACK_IN = ~SL_ACK_IN; tgl_done++;
                end else if (timer != 0) begin
                    timer--;
                    if (timer == 0) SL_ACK_IN = ~SL_ACK_IN;
                end
                if (SL_DATA_2OF7_OUT != prev) begin
                    automatic logic [6:0] sym = SL_DATA_2OF7_OUT ^ prev;
                    automatic int n = nib_of(sym);
                    prev = SL_DATA_2OF7_OUT;
                    if (traj_n < 256) begin traj[traj_n] = SL_DATA_2OF7_OUT; traj_n++; end
                    sym_total++;
                    last_sym_cyc = cyc;
                    if (spc_en) begin
                        if (spc_last >= 0 && cyc - spc_last < min_gap) min_gap = cyc - spc_last;
                        spc_last = cyc;
                    end
                    if (resp_en) timer = resp_dly;
                    if (n == 16) begin
                        if (rx_n < 64) begin rx_pkt[rx_n] = acc; rx_nsym[rx_n] = nib_n; rx_n++; end
                        acc = '0; nib_n = 0;
                    end else if (n == 17 || nib_n >= 18) begin
                        bad_n++;
                    end else begin
                        acc = acc | (72'(n) << (4 * nib_n));
                        nib_n++;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_pkt(input logic [71:0] p);
        int n = 0;
        @(negedge tb_clk);
        while (!PKT_RDY_OUT && n < 3000) begin @(negedge tb_clk); n++; end
        if (!PKT_RDY_OUT) begin
            checks++; errors++;
            $display("FAIL send_rdy_timeout: ready low for %0d cycles, required high", n);
        end else begin
            PKT_DATA_IN = p; PKT_VLD_IN = 1'b1;
            @(posedge tb_clk); #1;
            PKT_VLD_IN = 1'b0;
        end
    endtask

    int rd = 0;

    task automatic expect_pkt(input string nm, input vec_t v);
        int n = 0;
        while (rx_n <= rd && n < 6000) begin @(negedge tb_clk); n++; end
        if (rx_n <= rd) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no packet after %0d cycles, required one", nm, n);
        end else begin
            chk({nm, "_pkt"}, rx_pkt[rd], v.exp);
            chk({nm, "_nsym"}, 72'(rx_nsym[rd]), 72'(v.nsym));
            rd++;
        end
    endtask

    task automatic reset_outputs_chk(input string nm);
        chk({nm, "_data"}, 72'(SL_DATA_2OF7_OUT), 72'(0));
        chk({nm, "_rdy"},  72'(PKT_RDY_OUT), 72'(0));
        chk({nm, "_aerr"}, 72'(ACK_ERR_OUT), 72'(0));
        chk({nm, "_terr"}, 72'(TMO_ERR_OUT), 72'(0));
        chk({nm, "_cnt"},  72'(PKT_CNT_OUT), 72'(0));
    endtask

    initial begin
        vec_t tv;
        int   base, st, s0, t0, e0, n;
        logic [6:0] d0;

        tb_rst = 1'b1; PKT_DATA_IN = '0; PKT_VLD_IN = 1'b0;
        vt[0] = '{ {32'h0,        32'h00000001, 8'h00}, {32'h0,        32'h00000001, 8'h00}, 10 };
        vt[1] = '{ {32'hA5A5A5A5, 32'h12345678, 8'h02}, {32'hA5A5A5A5, 32'h12345678, 8'h02}, 18 };
        vt[2] = '{ {32'hFFFFFFFF, 32'hDEADBEEF, 8'hFD}, {32'h0,        32'hDEADBEEF, 8'hFD}, 10 };
        vt[3] = '{ {32'h89ABCDEF, 32'h01234567, 8'hFF}, {32'h89ABCDEF, 32'h01234567, 8'hFF}, 18 };

        repeat (3) @(negedge tb_clk);
        reset_outputs_chk("rst0");
        tb_rst = 1'b0;
        @(negedge tb_clk);
        chk("rdy_after_rst", 72'(PKT_RDY_OUT), 72'(1));

        // first toggle grants credit, second is spurious
        repeat (9) @(negedge tb_clk);
        tgl_req++;
        repeat (10) @(negedge tb_clk);
        tgl_req++;
        repeat (10) @(negedge tb_clk);
        chk("spurious_first", 72'(ack_err_n), 72'(1));
        chk("spurious_data", 72'(SL_DATA_2OF7_OUT), 72'(0));

        // basic packet with NRZ trajectory
        resp_en = 1'b1; resp_dly = 2;
        base = traj_n;
        send_pkt(vt[0].pkt);
        expect_pkt("basic", vt[0]);
        chk("traj0", 72'(traj[base]),     72'(7'h11));
        chk("traj1", 72'(traj[base + 1]), 72'(7'h00));
        chk("traj2", 72'(traj[base + 2]), 72'(7'h12));
        chk("traj3", 72'(traj[base + 3]), 72'(7'h03));
        chk("cnt_after_basic", 72'(PKT_CNT_OUT), 72'(1));

        for (int i = 0; i < 4; i++) begin
            send_pkt(vt[i].pkt);
            expect_pkt($sformatf("vec%0d", i), vt[i]);
        end
        repeat (20) @(negedge tb_clk);
        chk("cnt_after_table", 72'(PKT_CNT_OUT), 72'(5));

        // idle with credit: a single toggle is spurious
        e0 = ack_err_n; d0 = SL_DATA_2OF7_OUT;
        tgl_req++;
        repeat (10) @(negedge tb_clk);
        chk("idle_spurious", 72'(ack_err_n - e0), 72'(1));
        chk("idle_data", 72'(SL_DATA_2OF7_OUT), 72'(d0));

        // withheld ack -> timeout, then late ack
        resp_en = 1'b0;
        tv = '{ {32'h0, 32'h000000C3, 8'h00}, {32'h0, 32'h000000C3, 8'h00}, 10 };
        st = sym_total; t0 = tmo_n;
        send_pkt(tv.pkt);
        n = 0;
        while (sym_total == st && n < 100) begin @(negedge tb_clk); n++; end
        s0 = last_sym_cyc;
        n = 0;
        while (tmo_n == t0 && n < 200) begin @(negedge tb_clk); n++; end
        chk("tmo_latency", 72'(tmo_cyc - s0), 72'(ACK_TMO));
        repeat (60) @(negedge tb_clk);
        chk("tmo_once", 72'(tmo_n - t0), 72'(1));
        chk("tmo_one_sym", 72'(sym_total - st), 72'(1));
        resp_en = 1'b1;
        tgl_req++;
        expect_pkt("tmo_pkt", tv);

        // reset in mid-packet
        repeat (20) @(negedge tb_clk);
        send_pkt(vt[1].pkt);
        n = 0;
        while (nib_n < 5 && n < 500) begin @(negedge tb_clk); n++; end
        tb_rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        reset_outputs_chk("rst_mid");
        tb_rst = 1'b0;
        repeat (5) @(negedge tb_clk);
        tgl_req++;
        send_pkt(vt[3].pkt);
        expect_pkt("post_rst", vt[3]);
        chk("cnt_post_rst", 72'(PKT_CNT_OUT), 72'(1));

        // back-to-back packets with a slow responder
        repeat (20) @(negedge tb_clk);
        tb_rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        tb_rst = 1'b0;
        repeat (5) @(negedge tb_clk);
        resp_dly = 12; spc_en = 1'b1;
        tgl_req++;
        for (int i = 0; i < 8; i++) send_pkt(vt[i % 4].pkt);
        for (int i = 0; i < 8; i++) expect_pkt($sformatf("b2b%0d", i), vt[i % 4]);
        repeat (30) @(negedge tb_clk);
        chk("cnt_b2b", 72'(PKT_CNT_OUT), 72'(8));
        chk("min_spacing_ok", 72'(min_gap >= 7), 72'(1));
        spc_en = 1'b0;

        chk("ack_err_total", 72'(ack_err_n), 72'(2));
        chk("tmo_total", 72'(tmo_n), 72'(1));
        chk("bad_symbols", 72'(bad_n), 72'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
